// File: rtl/golomb_pkg.sv
// golomb_pkg: shared widths and scheduler state encoding for the Golomb ruler search.
package golomb_pkg;
    localparam int MARK_W  = 9;
    localparam int DEPTH_W = 4;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_CHECK,
        ST_ADVANCE,
        ST_BACKTRACK,
        ST_FINISH
    } sched_state_t;
endpackage

// File: rtl/mark_select.sv
// mark_select: picks one mark's position and ready bit out of the packed mark bus.
module mark_select
    import golomb_pkg::*;
#(
    parameter int NUM_MARKS = 4
) (
    input  logic [MARK_W*NUM_MARKS-1:0] vals,
    input  logic [NUM_MARKS-1:0]        rdy,
    input  logic [DEPTH_W-1:0]          idx,
    output logic [MARK_W-1:0]           val,
    output logic                        ready
);
    // Out-of-range indices (d-1 while d=0) read as an idle, zero mark.
    assign val   = (int'(idx) < NUM_MARKS) ? vals[int'(idx)*MARK_W +: MARK_W] : '0;
    assign ready = (int'(idx) < NUM_MARKS) ? rdy[idx] : 1'b0;
endmodule

// File: rtl/mark_chain_scheduler.sv
// mark_chain_scheduler: depth-first Golomb ruler search over external mark counters.
// Define SCHED_PRUNE_EN to tighten each mark's bound by the marks still to be placed.
module mark_chain_scheduler
    import golomb_pkg::*;
#(
    parameter int NUM_MARKS = 4,
    parameter int STEP_W    = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic [MARK_W-1:0]           maxLength,
    input  logic [MARK_W*NUM_MARKS-1:0] markVal,
    input  logic [NUM_MARKS-1:0]        markReady,
    output logic [NUM_MARKS-1:0]        markLoad,
    output logic [NUM_MARKS-1:0]        markAdvance,
    output logic [MARK_W-1:0]           loadValue,
    output logic                        checkReq,
    output logic [DEPTH_W-1:0]          checkDepth,
    input  logic                        checkDone,
    input  logic                        checkOk,
    output logic                        busy,
    output logic                        done,
    output logic                        found,
    output logic [MARK_W-1:0]           foundLength,
    output logic [STEP_W-1:0]           steps
);
    sched_state_t       state, state_n;
    logic [DEPTH_W-1:0] d;
    logic [DEPTH_W-1:0] d_prev;
    logic [MARK_W-1:0]  cur_val, prev_val, limit;
    logic               cur_rdy, prev_rdy_unused, last;

    assign d_prev = d - 1'b1;
    assign last   = (d == DEPTH_W'(NUM_MARKS - 1));

    mark_select #(.NUM_MARKS(NUM_MARKS)) sel_cur (
        .vals(markVal), .rdy(markReady), .idx(d), .val(cur_val), .ready(cur_rdy)
    );
    mark_select #(.NUM_MARKS(NUM_MARKS)) sel_prev (
        .vals(markVal), .rdy(markReady), .idx(d_prev), .val(prev_val), .ready(prev_rdy_unused)
    );

`ifdef SCHED_PRUNE_EN
    logic [MARK_W-1:0] slack;
    assign slack = MARK_W'(NUM_MARKS - 1) - MARK_W'(d);
    assign limit = (maxLength > slack) ? maxLength - slack : '0;
`else
    assign limit = maxLength;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            d           <= '0;
            done        <= 1'b0;
            found       <= 1'b0;
            foundLength <= '0;
            steps       <= '0;
        end else begin
            state <= state_n;
            case (state)
                ST_IDLE: if (start) begin
                    d           <= DEPTH_W'(1);
                    done        <= 1'b0;
                    found       <= 1'b0;
                    foundLength <= '0;
                    steps       <= '0;
                end
                ST_CHECK: if (checkDone) begin
                    steps <= (&steps) ? steps : steps + 1'b1;
                    if (checkOk && last) begin
                        found       <= 1'b1;
                        foundLength <= cur_val;
                    end else if (checkOk) d <= d + 1'b1;
                end
                ST_BACKTRACK: d <= d_prev;
                ST_FINISH:    done <= 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n     = state;
        markLoad    = (state == ST_LOAD) ? NUM_MARKS'(1) << d : '0;
        markAdvance = (state == ST_ADVANCE) ? NUM_MARKS'(1) << d : '0;
        loadValue   = (state == ST_LOAD) ? prev_val + MARK_W'(1) : '0;
        checkReq    = (state == ST_CHECK);
        checkDepth  = (state == ST_CHECK) ? d : '0;
        busy        = (state != ST_IDLE);
        case (state)
            ST_IDLE:      state_n = start ? ST_LOAD : ST_IDLE;
            ST_LOAD:      state_n = ST_WAIT;
            ST_ADVANCE:   state_n = ST_WAIT;
            ST_WAIT:      state_n = !cur_rdy ? ST_WAIT : (cur_val > limit) ? ST_BACKTRACK : ST_CHECK;
            ST_CHECK:     state_n = !checkDone ? ST_CHECK : !checkOk ? ST_ADVANCE : last ? ST_FINISH : ST_LOAD;
            ST_BACKTRACK: state_n = (d_prev == '0) ? ST_FINISH : ST_ADVANCE;
            ST_FINISH:    state_n = ST_IDLE;
            default:      state_n = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_mark_chain_scheduler.sv
// tb_mark_chain_scheduler: mark-counter and distance-checker models plus a software ruler search as reference.
module tb_mark_chain_scheduler;
    localparam int NM = 4;
    localparam int SW = 32;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [8:0]       maxLength = '0;
    logic [9*NM-1:0]  markVal;
    logic [NM-1:0]    markReady, markLoad, markAdvance;
    logic [8:0]       loadValue;
    logic             checkReq, checkDone, checkOk;
    logic [3:0]       checkDepth;
    logic             busy, done, found;
    logic [8:0]       foundLength;
    logic [SW-1:0]    steps;

    int passed = 0, total = 0, viol = 0;
    int mk_dly = 0, ck_dly = 0;
    logic [8:0] mval [NM];
    int         mcnt [NM];
    int         ccnt;

    mark_chain_scheduler #(.NUM_MARKS(NM), .STEP_W(SW)) dut (
        .clock(clock), .reset(reset), .start(start), .maxLength(maxLength),
        .markVal(markVal), .markReady(markReady), .markLoad(markLoad),
        .markAdvance(markAdvance), .loadValue(loadValue), .checkReq(checkReq),
        .checkDepth(checkDepth), .checkDone(checkDone), .checkOk(checkOk),
        .busy(busy), .done(done), .found(found), .foundLength(foundLength), .steps(steps)
    );

    always #5 clock = ~clock;

    function automatic bit distinct_dists(input int a[16], input int n);
        bit seen [512];
        for (int i = 0; i < 512; i++) seen[i] = 0;
        for (int i = 0; i <= n; i++)
            for (int j = i + 1; j <= n; j++) begin
                int dd = a[j] - a[i];
                if (dd < 0) dd = -dd;
                if (seen[dd % 512]) return 0;
                seen[dd % 512] = 1;
            end
        return 1;
    endfunction

    function automatic bit ruler_ok(input int depth);
        int a[16];
        for (int i = 0; i < 16; i++) a[i] = (i < NM) ? int'(mval[i]) : 0;
        return distinct_dists(a, depth);
    endfunction

    function automatic int lim(input int depth, input int maxl);
`ifdef SCHED_PRUNE_EN
        int s = maxl - (NM - 1 - depth);
        return (s < 0) ? 0 : s;
`else
        return maxl;
`endif
    endfunction

    // Lexicographic depth-first search; every candidate within bound costs one check.
    task automatic ref_search(input int maxl, output bit f, output int len, output int chk);
        int a[16];
        int dd;
        for (int i = 0; i < 16; i++) a[i] = 0;
        f = 0; len = 0; chk = 0; dd = 1; a[1] = 1;
        while (1) begin
            if (a[dd] > lim(dd, maxl)) begin
                dd--;
                if (dd == 0) break;
                a[dd]++;
            end else begin
                chk++;
                if (!distinct_dists(a, dd)) a[dd]++;
                else if (dd == NM - 1) begin f = 1; len = a[dd]; break; end
                else begin dd++; a[dd] = a[dd-1] + 1; end
            end
        end
    endtask

    always_comb begin
        markVal   = '0;
        markReady = '0;
        for (int i = 0; i < NM; i++) begin
            markVal[i*9 +: 9] = mval[i];
            markReady[i]      = (mcnt[i] == 0);
        end
    end

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NM; i++) begin mval[i] <= '0; mcnt[i] <= 0; end
            checkDone <= 1'b0; checkOk <= 1'b0; ccnt <= 0;
        end else begin
            for (int i = 1; i < NM; i++)
                if (markLoad[i]) begin mval[i] <= loadValue; mcnt[i] <= mk_dly; end
                else if (markAdvance[i]) begin mval[i] <= mval[i] + 9'd1; mcnt[i] <= mk_dly; end
                else if (mcnt[i] > 0) mcnt[i] <= mcnt[i] - 1;
            if (checkDone) checkDone <= 1'b0;
            else if (checkReq) begin
                if (ccnt >= ck_dly) begin
                    checkDone <= 1'b1;
                    checkOk   <= ruler_ok(int'(checkDepth));
                    ccnt      <= 0;
                end else ccnt <= ccnt + 1;
            end else ccnt <= 0;
        end
    end

    // Protocol monitor: commands never hit mark 0, stay one-hot, and never overlap a pending wait.
    always @(posedge clock) begin
        if (!reset) begin
            logic [NM-1:0] cmd;
            bit waiting;
            cmd = markLoad | markAdvance;
            waiting = 0;
            for (int i = 0; i < NM; i++) if (mcnt[i] != 0) waiting = 1;
            if (cmd[0] || $countones(cmd) > 1 || (cmd != 0 && (waiting || checkReq))) viol++;
            if (checkReq && checkDepth == 4'd0) viol++;
        end
    end

    task automatic launch(input int maxl, input int mk, input int ck);
        mk_dly = mk; ck_dly = ck; maxLength = 9'(maxl);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output bit to);
        to = 1;
        for (int c = 0; c < 20000; c++) begin
            if (done) begin to = 0; break; end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy); else passed++;
        total++; if ({done, found, foundLength} !== '0) $display("FAIL reset_result: got %0h expected 0", {done, found, foundLength}); else passed++;
        total++; if (steps !== '0) $display("FAIL reset_steps: got %0d expected 0", steps); else passed++;
        total++; if ({checkReq, checkDepth, markLoad, markAdvance, loadValue} !== '0) $display("FAIL reset_cmds: got %0h expected 0", {checkReq, checkDepth, markLoad, markAdvance, loadValue}); else passed++;
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_known(input int mk, input int ck, input string tag);
        bit to, ef; int el, ec, v0;
        ref_search(6, ef, el, ec);
        v0 = viol;
        launch(6, mk, ck);
        wait_done(to);
        total++; if (to) $display("FAIL %s_timeout: got no done expected done", tag); else passed++;
        total++; if ({done, found, busy} !== 3'b110) $display("FAIL %s_flags: got done/found/busy=%b expected 110", tag, {done, found, busy}); else passed++;
        total++; if (foundLength !== 9'd6 || foundLength !== 9'(el)) $display("FAIL %s_len: got %0d expected 6", tag, foundLength); else passed++;
        total++; if ({mval[1], mval[2], mval[3]} !== {9'd1, 9'd4, 9'd6}) $display("FAIL %s_marks: got %0d,%0d,%0d expected 1,4,6", tag, mval[1], mval[2], mval[3]); else passed++;
        total++; if (steps !== SW'(ec)) $display("FAIL %s_steps: got %0d expected %0d", tag, steps, ec); else passed++;
        total++; if (viol !== v0) $display("FAIL %s_protocol: got %0d violations expected 0", tag, viol - v0); else passed++;
        repeat (5) @(posedge clock);
        #1;
        total++; if ({done, found, foundLength} !== {1'b1, 1'b1, 9'd6}) $display("FAIL %s_hold: got %0h expected %0h", tag, {done, found, foundLength}, {1'b1, 1'b1, 9'd6}); else passed++;
    endtask

    task automatic test_not_found();
        bit to, ef; int el, ec;
        ref_search(5, ef, el, ec);
        launch(5, 1, 2);
        wait_done(to);
        total++; if (to) $display("FAIL nofind_timeout: got no done expected done"); else passed++;
        total++; if ({done, found, foundLength, busy} !== {1'b1, 1'b0, 9'd0, 1'b0}) $display("FAIL nofind_result: got done=%0b found=%0b len=%0d busy=%0b expected 1 0 0 0", done, found, foundLength, busy); else passed++;
        total++; if (steps !== SW'(ec)) $display("FAIL nofind_steps: got %0d expected %0d", steps, ec); else passed++;
    endtask

    task automatic test_reset_mid_check();
        bit seen = 0;
        mk_dly = 0; ck_dly = 6; maxLength = 9'd6;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            if (checkReq) seen = 1;
            else begin @(posedge clock); #1; end
        end
        total++; if (!seen) $display("FAIL midreset_req: got no checkReq expected checkReq"); else passed++;
        reset = 1'b1;
        @(posedge clock); #1;
        total++; if ({busy, done, found, foundLength, steps, checkReq, checkDepth, markLoad, markAdvance, loadValue} !== '0) $display("FAIL midreset_zero: got busy=%0b req=%0b depth=%0d steps=%0d expected all 0", busy, checkReq, checkDepth, steps); else passed++;
        reset = 1'b0;
        @(posedge clock); #1;
        test_known(0, 0, "after_reset");
    endtask

    task automatic test_start_while_busy();
        bit to, ef; int el, ec;
        ref_search(6, ef, el, ec);
        launch(6, 1, 1);
        for (int k = 0; k < 30; k++) begin
            start = (k % 7 == 3);
            @(posedge clock); #1;
        end
        start = 1'b0;
        wait_done(to);
        total++; if (to) $display("FAIL busystart_timeout: got no done expected done"); else passed++;
        total++; if ({found, foundLength} !== {1'b1, 9'd6}) $display("FAIL busystart_len: got found=%0b len=%0d expected 1 6", found, foundLength); else passed++;
        total++; if (steps !== SW'(ec)) $display("FAIL busystart_steps: got %0d expected %0d", steps, ec); else passed++;
    endtask

    task automatic test_random();
        bit to, ef; int el, ec, maxl, mk, ck, v0;
        for (int it = 0; it < 8; it++) begin
            maxl = $urandom_range(3, 11);
            mk = $urandom_range(0, 3);
            ck = $urandom_range(0, 4);
            ref_search(maxl, ef, el, ec);
            v0 = viol;
            launch(maxl, mk, ck);
            wait_done(to);
            total++; if (to || found !== ef || foundLength !== 9'(el)) $display("FAIL rand%0d_result maxl=%0d: got found=%0b len=%0d expected found=%0b len=%0d", it, maxl, found, foundLength, ef, el); else passed++;
            total++; if (steps !== SW'(ec) || viol !== v0) $display("FAIL rand%0d_steps maxl=%0d: got %0d (viol %0d) expected %0d (viol 0)", it, maxl, steps, viol - v0, ec); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_known(0, 0, "known");
        test_not_found();
        test_known(3, 5, "slow");
        test_reset_mid_check();
        test_start_while_busy();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
